fifo_order_checker: RTL

FIFO_ORDER_CHECKER -- requirements
Module: fifo_order_checker

---
 rtl/fifo_order_checker.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fifo_order_checker.sv
// Passive in-order scoreboard for a FIFO: mirrors accepted writes and checks every accepted read.
// Define FIFO_ORDER_CHECKER_STABILITY_EN to also flag read-side valid drops and unstable rdata.
module fifo_order_checker #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_cg,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_wvalid,
   input  logic                     i_wready,
   input  logic [WIDTH-1:0]         i_rdata,
   input  logic                     i_rvalid,
   input  logic                     i_rready,
   output logic                     o_error,
   output logic [2:0]               o_errCode,
   output logic [WIDTH-1:0]         o_errExpected,
   output logic [WIDTH-1:0]         o_errActual,
   output logic [CNT_W-1:0]         o_nPushed,
   output logic [CNT_W-1:0]         o_nPopped,
   output logic [$clog2(DEPTH):0]   o_nEntries
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned EntW = PtrW + 1;
   localparam logic [EntW-1:0] Full = EntW'(DEPTH);

   localparam logic [2:0] ErrNone      = 3'd0;
   localparam logic [2:0] ErrMismatch  = 3'd1;
   localparam logic [2:0] ErrUnderflow = 3'd2;
   localparam logic [2:0] ErrOverflow  = 3'd3;
   localparam logic [2:0] ErrDropped   = 3'd4;
   localparam logic [2:0] ErrUnstable  = 3'd5;

   typedef enum logic {StRun, StFail} state_e;

   state_e                state_q, state_d;
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [EntW-1:0]       n_q, n_d;
   logic [CNT_W-1:0]      pushed_q, pushed_d, popped_q, popped_d;
   logic                  error_q, error_d;
   logic [2:0]            code_q, code_d;
   logic [WIDTH-1:0]      exp_q, exp_d, act_q, act_d;
   logic [WIDTH-1:0]      mem_q [DEPTH];

   logic [WIDTH-1:0]      head;
   logic                  push, pop, push_eff, legal_pop;
   logic                  underflow, overflow, mismatch, dropped, unstable;
   logic [2:0]            err_code;

   assign head = mem_q[rd_ptr_q];

`ifdef FIFO_ORDER_CHECKER_STABILITY_EN
   logic                  prev_valid_q, prev_ready_q;
   logic [WIDTH-1:0]      prev_data_q;
   logic                  stalled;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         prev_valid_q <= 1'b0;
         prev_ready_q <= 1'b0;
         prev_data_q  <= '0;
      end else if (i_cg) begin
         prev_valid_q <= i_rvalid;
         prev_ready_q <= i_rready;
         prev_data_q  <= i_rdata;
      end
   end

   assign stalled  = i_cg & prev_valid_q & ~prev_ready_q;
   assign dropped  = stalled & ~i_rvalid;
   assign unstable = stalled & (i_rdata != prev_data_q);
`else
   assign dropped  = 1'b0;
   assign unstable = 1'b0;
`endif

   always_comb begin
      push      = i_cg & i_wvalid & i_wready;
      pop       = i_cg & i_rvalid & i_rready;
      // No bypass: a pop against an empty model is an underflow even with a same-cycle push.
      underflow = pop & (n_q == '0);
      legal_pop = pop & ~underflow;
      overflow  = push & (n_q == Full) & ~pop;
      push_eff  = push & ~overflow;
      mismatch  = legal_pop & (i_rdata != head);

      if (underflow)     err_code = ErrUnderflow;
      else if (overflow) err_code = ErrOverflow;
      else if (mismatch) err_code = ErrMismatch;
      else if (dropped)  err_code = ErrDropped;
      else if (unstable) err_code = ErrUnstable;
      else               err_code = ErrNone;
   end

   always_comb begin
      wr_ptr_d = push_eff ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = legal_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      n_d      = n_q;
      if (push_eff && !legal_pop) n_d = n_q + EntW'(1);
      if (legal_pop && !push_eff) n_d = n_q - EntW'(1);
      pushed_d = push ? pushed_q + CNT_W'(1) : pushed_q;
      popped_d = pop ? popped_q + CNT_W'(1) : popped_q;

      state_d = state_q;
      error_d = error_q;
      code_d  = code_q;
      exp_d   = exp_q;
      act_d   = act_q;
      if (state_q == StRun && err_code != ErrNone) begin
         state_d = StFail;
         error_d = 1'b1;
         code_d  = err_code;
         exp_d   = underflow ? '0 : head;
         act_d   = i_rdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= StRun;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         n_q      <= '0;
         pushed_q <= '0;
         popped_q <= '0;
         error_q  <= 1'b0;
         code_q   <= ErrNone;
         exp_q    <= '0;
         act_q    <= '0;
      end else if (i_cg) begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         n_q      <= n_d;
         pushed_q <= pushed_d;
         popped_q <= popped_d;
         error_q  <= error_d;
         code_q   <= code_d;
         exp_q    <= exp_d;
         act_q    <= act_d;
      end
   end

   // Model storage is deliberately left out of reset; occupancy alone decides validity.
   always_ff @(posedge i_clk) begin
      if (push_eff) mem_q[wr_ptr_q] <= i_wdata;
   end

   assign o_error       = error_q;
   assign o_errCode     = code_q;
   assign o_errExpected = exp_q;
   assign o_errActual   = act_q;
   assign o_nPushed     = pushed_q;
   assign o_nPopped     = popped_q;
   assign o_nEntries    = n_q;

endmodule
